// File: rtl/pdp_mem_arbiter_if.sv
// rtl/pdp_mem_arbiter_if.sv - Requester, response and memory-port bundle for pdp_mem_arbiter
interface pdp_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic                  ifu_rd_gnt;
  logic                  ifu_rd_valid;
  logic [DATA_WIDTH-1:0] ifu_rd_data;

  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic                  exec_rd_gnt;
  logic                  exec_rd_valid;
  logic [DATA_WIDTH-1:0] exec_rd_data;

  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  exec_wr_gnt;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  arb_busy;

  // Arbiter side
  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    input  exec_rd_req, exec_rd_addr,
    input  exec_wr_req, exec_wr_addr, exec_wr_data,
    input  mem_rdata,
    output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
    output exec_rd_gnt, exec_rd_valid, exec_rd_data,
    output exec_wr_gnt,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output arb_busy
  );

  // Requesters plus memory side
  modport master (
    output ifu_rd_req, ifu_rd_addr,
    output exec_rd_req, exec_rd_addr,
    output exec_wr_req, exec_wr_addr, exec_wr_data,
    output mem_rdata,
    input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
    input  exec_rd_gnt, exec_rd_valid, exec_rd_data,
    input  exec_wr_gnt,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  arb_busy
  );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// rtl/pdp_mem_arbiter.sv - PDP-8 fetch/exec single-port memory arbiter with fixed-latency reads
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LAT     = 1,
  parameter int FAIR_LIMIT = 4
) (
  input logic              clk,
  input logic              reset_n,
  pdp_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_EXEC_RD, OWN_EXEC_WR} owner_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

  state_t state;
  state_t state_next;
  owner_t owner;
  owner_t pick;
  logic   fair_force;

  logic [2:0] wait_cnt;
  logic [3:0] fair_cnt;

  logic                  ifu_gnt_q;
  logic                  exec_rd_gnt_q;
  logic                  exec_wr_gnt_q;
  logic                  ifu_valid_q;
  logic                  exec_valid_q;
  logic [DATA_WIDTH-1:0] ifu_data_q;
  logic [DATA_WIDTH-1:0] exec_data_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  busy_q;

  // Winner of the current IDLE sample; fetch jumps the queue once starved long enough
  always_comb begin
    pick       = OWN_NONE;
    fair_force = bus.ifu_rd_req && (fair_cnt == FAIR_MAX);
    if (fair_force) begin
      pick = OWN_IFU;
    end else if (bus.exec_wr_req) begin
      pick = OWN_EXEC_WR;
    end else if (bus.exec_rd_req) begin
      pick = OWN_EXEC_RD;
    end else if (bus.ifu_rd_req) begin
      pick = OWN_IFU;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick != OWN_NONE) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = (owner == OWN_EXEC_WR) ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_NONE;
      wait_cnt <= '0;
      fair_cnt <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (state == IDLE && pick != OWN_NONE) begin
        owner <= pick;
        if (pick == OWN_IFU || !bus.ifu_rd_req) begin
          fair_cnt <= '0;
        end else if (fair_cnt != FAIR_MAX) begin
          fair_cnt <= fair_cnt + 4'd1;
        end
      end
    end
  end

  // Strobes default low each cycle; the memory bus fields hold between transactions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifu_gnt_q     <= 1'b0;
      exec_rd_gnt_q <= 1'b0;
      exec_wr_gnt_q <= 1'b0;
      ifu_valid_q   <= 1'b0;
      exec_valid_q  <= 1'b0;
      ifu_data_q    <= '0;
      exec_data_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      ifu_gnt_q     <= 1'b0;
      exec_rd_gnt_q <= 1'b0;
      exec_wr_gnt_q <= 1'b0;
      ifu_valid_q   <= 1'b0;
      exec_valid_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      busy_q        <= (state_next != IDLE);

      if (state == IDLE && pick != OWN_NONE) begin
        mem_req_q <= 1'b1;
        case (pick)
          OWN_EXEC_WR: begin
            exec_wr_gnt_q <= 1'b1;
            mem_we_q      <= 1'b1;
            mem_addr_q    <= bus.exec_wr_addr;
            mem_wdata_q   <= bus.exec_wr_data;
          end
          OWN_EXEC_RD: begin
            exec_rd_gnt_q <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= bus.exec_rd_addr;
          end
          OWN_IFU: begin
            ifu_gnt_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.ifu_rd_addr;
          end
          default: begin
          end
        endcase
      end

      if (state == WAIT && wait_cnt == LAT_LAST) begin
        if (owner == OWN_IFU) begin
          ifu_data_q  <= bus.mem_rdata;
          ifu_valid_q <= 1'b1;
        end else begin
          exec_data_q  <= bus.mem_rdata;
          exec_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ifu_rd_gnt    = ifu_gnt_q;
  assign bus.ifu_rd_valid  = ifu_valid_q;
  assign bus.ifu_rd_data   = ifu_data_q;
  assign bus.exec_rd_gnt   = exec_rd_gnt_q;
  assign bus.exec_rd_valid = exec_valid_q;
  assign bus.exec_rd_data  = exec_data_q;
  assign bus.exec_wr_gnt   = exec_wr_gnt_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.arb_busy      = busy_q;

endmodule
